// File: rtl/rock_pkg.sv
// Shared types and constants for the cradle rocking driver.
// The package holds the FSM encoding, the default timebase scaling and the datapath widths.
package rock_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWING_POS = 2'd1,
    SWING_NEG = 2'd2,
    HOME      = 2'd3
  } rock_state_t;

  localparam int unsigned STEP_UNIT_DEF = 4;
  localparam int POS_W = 4;
  localparam int AMP_W = 3;
  // Wide enough for STEP_UNIT*8 with STEP_UNIT up to 255.
  localparam int CNT_W = 11;

endpackage

// File: rtl/rock_step_timer.sv
// Tick-interval counter: expire pulses on the tick that completes one step interval.
// The count is held while tick is low, and is zeroed by clear or by reset.
module rock_step_timer
  import rock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] interval,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = tick && !clear && (cnt == interval - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      if (expire) cnt <= '0;
      else        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rock_driver.sv
// Cradle rocking driver: swings a stepper between +/-amplitude at a tick-based rate,
// then homes the cradle to centre when a stop is requested.
//
// state     | meaning
// IDLE      | parked at pos 0, no steps, waiting for a non-zero F and A
// SWING_POS | stepping toward +amp_l
// SWING_NEG | stepping toward -amp_l
// HOME      | stop requested, stepping back toward pos 0
module rock_driver
  import rock_pkg::*;
#(
  parameter int unsigned STEP_UNIT = STEP_UNIT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [2:0]              F,
  input  logic [AMP_W-1:0]        A,
  input  logic                    F0,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] pos,
  output logic                    busy
);

  rock_state_t state, state_n;

  logic signed [POS_W-1:0] pos_n, pos_step, amp_s;
  logic [AMP_W-1:0]        amp_l, amp_n;
  logic [2:0]              frq_l, frq_n;
  logic [CNT_W-1:0]        interval;
  logic                    stop_req, step_dir, step_n, dir_n, busy_n;
  logic                    clear, expire;

  assign stop_req = F0 | (F == 3'd0) | (A == '0);
  assign interval = CNT_W'(STEP_UNIT) * CNT_W'(4'd8 - {1'b0, frq_l});
  assign amp_s    = $signed({1'b0, amp_l});
  assign pos_step = step_dir ? (pos + 4'sd1) : (pos - 4'sd1);

  rock_step_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .clear    (clear),
    .interval (interval),
    .expire   (expire)
  );

  always_comb begin
    step_dir = 1'b1;
    case (state)
      SWING_NEG: step_dir = 1'b0;
      HOME:      step_dir = (pos < 4'sd0);
      default:   step_dir = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    step_n  = 1'b0;
    amp_n   = amp_l;
    frq_n   = frq_l;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        dir_n = 1'b1;
        if (!stop_req) begin
          amp_n   = A;
          frq_n   = F;
          state_n = SWING_POS;
        end
      end
      SWING_POS, SWING_NEG: begin
        dir_n = step_dir;
        // A step due in the same cycle as a stop request is still taken.
        if (expire) begin
          step_n = 1'b1;
          pos_n  = pos_step;
          if (pos_step == 4'sd0) begin
            amp_n = A;
            frq_n = F;
          end
          if (state == SWING_POS && pos_step == amp_s)  state_n = SWING_NEG;
          if (state == SWING_NEG && pos_step == -amp_s) state_n = SWING_POS;
        end
        if (stop_req) state_n = HOME;
      end
      HOME: begin
        dir_n = step_dir;
        if (pos == 4'sd0) begin
          state_n = IDLE;
        end else if (expire) begin
          step_n = 1'b1;
          pos_n  = pos_step;
          if (pos_step == 4'sd0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pos   <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      busy  <= 1'b0;
      amp_l <= '0;
      frq_l <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      dir   <= dir_n;
      step  <= step_n;
      busy  <= busy_n;
      amp_l <= amp_n;
      frq_l <= frq_n;
    end
  end

endmodule

// File: tb/tb_rock_driver.sv
// Directed bench for rock_driver: two instances (STEP_UNIT=1 and 4) share stimulus;
// outputs are sampled on the falling edge against hand-computed sequences.
module tb_rock_driver;

  logic       clk = 1'b0;
  logic       reset, tick, F0;
  logic [2:0] F, A;
  logic       step1, dir1, busy1, step4, dir4, busy4;
  logic signed [3:0] pos1, pos4;

  int checks   = 0;
  int failures = 0;
  int gap, cnt;

  always #5 clk = ~clk;

  rock_driver #(.STEP_UNIT(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .F(F), .A(A), .F0(F0),
    .step(step1), .dir(dir1), .pos(pos1), .busy(busy1)
  );

  rock_driver #(.STEP_UNIT(4)) dut4 (
    .clk(clk), .reset(reset), .tick(tick), .F(F), .A(A), .F0(F0),
    .step(step4), .dir(dir4), .pos(pos4), .busy(busy4)
  );

  task check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until a step is seen, or -1 on timeout.
  task wait_step(input bit use4, input int budget, output int g);
    g = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((use4 ? step4 : step1) === 1'b1) begin
        g = i;
        break;
      end
    end
  endtask

  task count_steps(input bit use4, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if ((use4 ? step4 : step1) === 1'b1) n++;
    end
  endtask

  // Runs through a list of expected positions on dut1, each step 2 clocks apart.
  task follow1(input string tag, input int exp_pos[$]);
    foreach (exp_pos[k]) begin
      wait_step(1'b0, 10, gap);
      check_eq({tag, "_gap"}, gap, 2);
      check_eq({tag, "_pos"}, int'(pos1), exp_pos[k]);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_pos[$];
    int seq_dir[$];

    // Start-up and basic swing, STEP_UNIT=1, F=6 -> interval 2
    reset = 1'b1; tick = 1'b1; F = 3'd6; A = 3'd2; F0 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pos",  int'(pos1), 0);
    check_eq("rst_step", int'(step1), 0);
    check_eq("rst_busy", int'(busy1), 0);
    check_eq("rst_dir",  int'(dir1), 1);
    check_eq("rst_busy4", int'(busy4), 0);
    reset = 1'b0;

    wait_step(1'b0, 10, gap);
    check_eq("first_lat", gap, 3);
    check_eq("first_pos", int'(pos1), 1);
    check_eq("first_dir", int'(dir1), 1);
    check_eq("swing_busy", int'(busy1), 1);

    seq_pos = '{2, 1, 0, -1, -2, -1, 0, 1};
    seq_dir = '{1, 0, 0, 0, 0, 1, 1, 1};
    foreach (seq_pos[k]) begin
      wait_step(1'b0, 10, gap);
      check_eq("swing_gap", gap, 2);
      check_eq("swing_pos", int'(pos1), seq_pos[k]);
      check_eq("swing_dir", int'(dir1), seq_dir[k]);
    end

    // Amplitude change at pos=+1 only takes effect at the next zero crossing
    A = 3'd3;
    follow1("amp3", '{2, 1, 0, -1, -2, -3, -2, -1, 0, 1, 2, 3, 2, 1, 0, -1, -2});

    // Stop at pos=-2: home with dir=1 at the same interval, then idle
    F0 = 1'b1;
    wait_step(1'b0, 10, gap);
    check_eq("home1_gap", gap, 2);
    check_eq("home1_pos", int'(pos1), -1);
    check_eq("home1_dir", int'(dir1), 1);
    wait_step(1'b0, 10, gap);
    check_eq("home2_gap", gap, 2);
    check_eq("home2_pos", int'(pos1), 0);
    check_eq("home2_dir", int'(dir1), 1);
    check_eq("home_idle_busy", int'(busy1), 0);
    count_steps(1'b0, 20, cnt);
    check_eq("idle_nostep", cnt, 0);
    check_eq("idle_pos", int'(pos1), 0);

    // Slow rate on STEP_UNIT=4, F=1 -> interval 28 ticks
    reset = 1'b1; F = 3'd1; A = 3'd7; F0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_step(1'b1, 100, gap);
    check_eq("slow_first_lat", gap, 29);
    check_eq("slow_pos1", int'(pos4), 1);
    wait_step(1'b1, 100, gap);
    check_eq("slow_gap", gap, 28);
    check_eq("slow_pos2", int'(pos4), 2);
    count_steps(1'b1, 5, cnt);
    tick = 1'b0;
    count_steps(1'b1, 10, gap);
    cnt = cnt + gap;
    check_eq("hold_nostep", cnt, 0);
    check_eq("hold_pos", int'(pos4), 2);
    tick = 1'b1;
    wait_step(1'b1, 100, gap);
    check_eq("resume_gap", gap, 23);
    check_eq("resume_pos", int'(pos4), 3);

    // Reset arriving on the edge where the step to +2 would fire
    reset = 1'b1; F = 3'd6; A = 3'd2;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_step(1'b0, 10, gap);
    check_eq("pre_rst_lat", gap, 3);
    @(negedge clk);
    check_eq("pre_rst_pos", int'(pos1), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_pos",  int'(pos1), 0);
    check_eq("mid_rst_step", int'(step1), 0);
    check_eq("mid_rst_busy", int'(busy1), 0);
    check_eq("mid_rst_dir",  int'(dir1), 1);
    A = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    count_steps(1'b0, 15, cnt);
    check_eq("a0_nostep", cnt, 0);
    check_eq("a0_busy", int'(busy1), 0);
    check_eq("a0_pos", int'(pos1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
